// File: rtl/ifid_pipe.sv
// ifid_pipe -- two-entry IF/ID pipeline register with skid buffer.
//
// The main register drives the decode-side outputs. The skid register
// absorbs one extra entry when decode stalls, so in_ready_o can be a plain
// register instead of a combinational path from out_ready_i. A jump flushes
// every held entry and any entry offered in the same cycle.
//
// Optional feature: define IFID_PERF_CNT_EN to build saturating flush and
// stall counters. Without it both counter ports are tied to zero.

module ifid_pipe #(
  parameter int                 INSTR_W   = 32,
  parameter int                 ADDR_W    = 14,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000013),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               jump_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] Instr_i,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] Instr_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [CNT_W-1:0]   flush_cnt_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [ADDR_W-1:0]  main_addr_q, main_addr_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]  skid_addr_q, skid_addr_d;

  logic up_xfer;
  logic dn_xfer;

  assign up_xfer = in_valid_i && in_ready_q;
  assign dn_xfer = out_valid_q && out_ready_i;

  // Next-state and datapath selection; a jump overrides every other event.
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_addr_d  = main_addr_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;

    if (jump_i) begin
      state_d      = EMPTY;
      main_instr_d = NOP_INSTR;
      main_addr_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (up_xfer) begin
            state_d      = ONE;
            main_instr_d = Instr_i;
            main_addr_d  = addr_i;
          end
        end
        ONE: begin
          if (up_xfer && dn_xfer) begin
            main_instr_d = Instr_i;
            main_addr_d  = addr_i;
          end else if (up_xfer) begin
            state_d      = TWO;
            skid_instr_d = Instr_i;
            skid_addr_d  = addr_i;
          end else if (dn_xfer) begin
            state_d      = EMPTY;
            main_instr_d = NOP_INSTR;
            main_addr_d  = '0;
          end
        end
        TWO: begin
          // in_ready_q is low here, so only the drain side can move.
          if (dn_xfer) begin
            state_d      = ONE;
            main_instr_d = skid_instr_q;
            main_addr_d  = skid_addr_q;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_instr_d = NOP_INSTR;
          main_addr_d  = '0;
        end
      endcase
    end

    // Handshake outputs are decoded from the next state and then registered.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  // FSM state, handshake flags and main entry; reset leaves a bubble on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      main_instr_q <= NOP_INSTR;
      main_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      main_instr_q <= main_instr_d;
      main_addr_q  <= main_addr_d;
    end
  end

  // Skid entry payload; only meaningful in TWO, so it carries no reset.
  always_ff @(posedge clk) begin
    skid_instr_q <= skid_instr_d;
    skid_addr_q  <= skid_addr_d;
  end

  assign out_valid_o = out_valid_q;
  assign in_ready_o  = in_ready_q;
  assign Instr_o     = main_instr_q;
  assign addr_o      = main_addr_q;

`ifdef IFID_PERF_CNT_EN

  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Saturating event counters: jump cycles and stalled-decode cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (jump_i) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
      if (out_valid_q && !out_ready_i) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
    end
  end

  assign flush_cnt_o = flush_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

`else

  assign flush_cnt_o = '0;
  assign stall_cnt_o = '0;

`endif

endmodule

// File: tb/tb_ifid_pipe.sv
// Scoreboard bench for ifid_pipe: the model is a bounded FIFO of depth two
// plus two saturating counters; the driver pushes accepted entries and the
// monitor checks and pops whatever the DUT presents.
`timescale 1ns/100ps

module tb_ifid_pipe;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 14;
  localparam int CNT_W   = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk;
  logic               rst_n;
  logic               jump_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [INSTR_W-1:0] Instr_i;
  logic [ADDR_W-1:0]  addr_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [INSTR_W-1:0] Instr_o;
  logic [ADDR_W-1:0]  addr_o;
  logic [CNT_W-1:0]   flush_cnt_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  ifid_pipe #(
    .INSTR_W  (INSTR_W),
    .ADDR_W   (ADDR_W),
    .NOP_INSTR(NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .jump_i     (jump_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .Instr_i    (Instr_i),
    .addr_i     (addr_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .Instr_o    (Instr_o),
    .addr_o     (addr_o),
    .flush_cnt_o(flush_cnt_o),
    .stall_cnt_o(stall_cnt_o)
  );

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  addr;
  } ent_t;

  ent_t exp_q[$];
  int   flush_m;
  int   stall_m;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int v);
`ifdef IFID_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Monitor: two time units after each falling edge, compare against the queue head.
  initial begin
    int   sz;
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      sz = exp_q.size();
      chk("out_valid", out_valid_o, sz > 0);
      chk("in_ready", in_ready_o, sz < 2);
      if (sz > 0) begin
        e = exp_q[0];
        chk("instr", Instr_o, e.instr);
        chk("addr", addr_o, e.addr);
        if (out_valid_o && out_ready_i && rst_n)
          e = exp_q.pop_front();
      end else begin
        chk("instr_bubble", Instr_o, NOP);
        chk("addr_bubble", addr_o, 0);
      end
      chk("flush_cnt", flush_cnt_o, exp_cnt(flush_m));
      chk("stall_cnt", stall_cnt_o, exp_cnt(stall_m));
    end
  end

  // One clock of stimulus; the model advances after the monitor has popped.
  task automatic step(input logic v, input logic [31:0] ins, input logic [13:0] a,
                      input logic r, input logic j, output logic acc);
    int occ;
    ent_t e;
    @(negedge clk);
    #1;
    in_valid_i  = v;
    Instr_i     = ins;
    addr_i      = a;
    out_ready_i = r;
    jump_i      = j;
    occ         = exp_q.size();
    #2;
    acc = 1'b0;
    if (rst_n) begin
      if (occ > 0 && !r && stall_m < CNT_MAX) stall_m++;
      if (j) begin
        if (flush_m < CNT_MAX) flush_m++;
        exp_q.delete();
      end else if (v && occ < 2) begin
        e.instr = ins;
        e.addr  = a;
        exp_q.push_back(e);
        acc = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    in_valid_i = 1'b0; out_ready_i = 1'b0; jump_i = 1'b0;
    exp_q.delete();
    flush_m = 0;
    stall_m = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic        acc;
    logic [31:0] nxt;
    n_checks = 0; n_fail = 0; flush_m = 0; stall_m = 0;
    rst_n = 1'b0; jump_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    Instr_i = '0; addr_i = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Single entry, latency one.
    step(1, 32'h12345678, 14'h0001, 1, 0, acc);
    step(0, 0, 0, 1, 0, acc);
    step(0, 0, 0, 1, 0, acc);

    // Fill both entries while stalled, then drain in order.
    step(1, 32'h000000A1, 14'h00A1, 0, 0, acc);
    step(1, 32'h000000A2, 14'h00A2, 0, 0, acc);
    step(1, 32'h000000A3, 14'h00A3, 0, 0, acc);
    step(0, 0, 0, 1, 0, acc);
    step(0, 0, 0, 1, 0, acc);
    step(0, 0, 0, 1, 0, acc);

    // Flush from TWO with a same-cycle incoming entry.
    step(1, 32'h000000B1, 14'h00B1, 0, 0, acc);
    step(1, 32'h000000B2, 14'h00B2, 0, 0, acc);
    step(1, 32'h00000001, 14'h0005, 0, 1, acc);
    step(0, 0, 0, 1, 0, acc);
    step(0, 0, 0, 1, 0, acc);

    // Continuous stream with toggling downstream ready.
    nxt = 32'h10;
    for (int i = 0; i < 64 && nxt <= 32'h1F; i++) begin
      step(1, nxt, nxt[13:0], i[0] == 1'b0, 0, acc);
      if (acc) nxt++;
    end
    chk("stream_done", nxt, 32'h20);
    repeat (3) step(0, 0, 0, 1, 0, acc);

    // Asynchronous reset between edges while holding two entries.
    step(1, 32'h000000C1, 14'h00C1, 0, 0, acc);
    step(1, 32'h000000C2, 14'h00C2, 0, 0, acc);
    #0.5;
    rst_n = 1'b0;
    #0.5;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_instr", Instr_o, NOP);
    chk("rst_addr", addr_o, 0);
    chk("rst_flush_cnt", flush_cnt_o, 0);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    exp_q.delete();
    flush_m = 0;
    stall_m = 0;
    @(negedge clk);
    #1;
    in_valid_i = 1'b0; out_ready_i = 1'b0; jump_i = 1'b0;
    rst_n = 1'b1;
    step(1, 32'h0000BEEF, 14'h0BEE, 1, 0, acc);
    step(0, 0, 0, 1, 0, acc);

    // Counter saturation: 20+ stall cycles and exactly 3 flushes.
    do_reset();
    step(1, 32'h000000D1, 14'h00D1, 0, 0, acc);
    repeat (20) step(0, 0, 0, 0, 0, acc);
    repeat (3) step(0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 1, 0, acc);
    @(negedge clk);
    #2;
`ifdef IFID_PERF_CNT_EN
    chk("stall_sat", stall_cnt_o, 15);
    chk("flush_three", flush_cnt_o, 3);
`else
    chk("stall_tied", stall_cnt_o, 0);
    chk("flush_tied", flush_cnt_o, 0);
`endif

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, $urandom, 14'($urandom), ($urandom % 2) == 0,
           ($urandom % 16) == 0, acc);
    end
    repeat (4) step(0, 0, 0, 1, 0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_pipe.md
IFID_PIPE -- requirements
Module: ifid_pipe

Interface
REQ-001 The block SHALL expose parameter INSTR_W, default 32, meaning instruction width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 14, meaning fetch address width in bits.
REQ-003 The block SHALL expose parameter NOP_INSTR, default 32'h00000013, meaning the bubble instruction driven when no valid entry is held.
REQ-004 The block SHALL expose parameter CNT_W, default 16, meaning performance counter width.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 jump_i  input  1  flush request; discards all held and incoming entries.
REQ-008 in_valid_i  input  1  upstream (IF) entry valid.
REQ-009 in_ready_o  output  1  block can accept an upstream entry this cycle.
REQ-010 Instr_i  input  INSTR_W  fetched instruction.
REQ-011 addr_i  input  ADDR_W  fetch address of Instr_i.
REQ-012 out_valid_o  output  1  Instr_o/addr_o hold a valid entry.
REQ-013 out_ready_i  input  1  downstream (ID) accepts the entry this cycle.
REQ-014 Instr_o  output  INSTR_W  instruction to decode.
REQ-015 addr_o  output  ADDR_W  address of Instr_o.
REQ-016 flush_cnt_o  output  CNT_W  count of flush events.
REQ-017 stall_cnt_o  output  CNT_W  count of downstream stall cycles.

Function
REQ-018 Storage SHALL be two entries: main register (drives outputs) and skid register; all outputs registered except none combinational from inputs.
REQ-019 Upstream transfer SHALL occur when in_valid_i && in_ready_o; downstream transfer when out_valid_o && out_ready_i.
REQ-020 in_ready_o SHALL be 1 exactly when the skid register is empty, registered.
REQ-021 State machine SHALL have states EMPTY (no entries), ONE (main only), TWO (main and skid).
REQ-022 EMPTY: upstream transfer -> ONE, entry in main next cycle (latency 1).
REQ-023 ONE: upstream and downstream together -> ONE with new entry; upstream only -> TWO, entry into skid; downstream only -> EMPTY; neither -> ONE.
REQ-024 TWO: downstream transfer -> ONE, skid moves to main; otherwise hold; no upstream accepted (in_ready_o=0).
REQ-025 Entries SHALL leave in arrival order; no entry duplicated or dropped except by flush.
REQ-026 jump_i=1 SHALL force next state EMPTY, discard both entries and any same-cycle upstream entry; flush wins over all simultaneous events.
REQ-027 In EMPTY, Instr_o SHALL equal NOP_INSTR and addr_o SHALL equal 0.
REQ-028 Outputs SHALL hold stable while out_valid_o=1 and out_ready_i=0.

Reset
REQ-029 rst_n=0 SHALL asynchronously force EMPTY: out_valid_o=0, in_ready_o=1, Instr_o=NOP_INSTR, addr_o=0, flush_cnt_o=0, stall_cnt_o=0.
REQ-030 Reset asserted mid-operation SHALL discard all entries; first upstream transfer after release appears on outputs one cycle later.

Configuration
REQ-031 Macro IFID_PERF_CNT_EN defined: flush_cnt_o SHALL increment per cycle with jump_i=1; stall_cnt_o SHALL increment per cycle with out_valid_o=1 && out_ready_i=0; both saturate at 2^CNT_W-1.
REQ-032 Macro IFID_PERF_CNT_EN undefined: counter logic SHALL be absent, flush_cnt_o and stall_cnt_o tied to 0, ports retained.

Verification
REQ-033 Reset, then in_valid_i=1, Instr_i=32'h12345678, addr_i=14'h0001, out_ready_i=1 -> next cycle out_valid_o=1, Instr_o=32'h12345678, addr_o=14'h0001.
REQ-034 out_ready_i=0, push 32'hA1 then 32'hA2 -> in_ready_o=0 after second push, Instr_o=32'hA1 held; raise out_ready_i -> 32'hA1 then 32'hA2 on consecutive cycles, in_ready_o=1.
REQ-035 TWO state, jump_i=1 with in_valid_i=1, Instr_i=32'h00000001 -> next cycle out_valid_o=0, Instr_o=32'h00000013, addr_o=0; 32'h00000001 never appears.
REQ-036 Continuous stream 32'h10..32'h1F, out_ready_i toggling 1/0 -> output sequence 32'h10..32'h1F in order, no gaps or repeats.
REQ-037 IFID_PERF_CNT_EN, CNT_W=4, 20 stall cycles and 3 flushes -> stall_cnt_o=15, flush_cnt_o=3; undefined -> both 0.
REQ-038 rst_n=0 asserted between clock edges in TWO -> immediately out_valid_o=0, in_ready_o=1, Instr_o=32'h00000013.
